// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-cycle iterative shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied on the final step.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        f3_q, f3_n;
    logic              neg_main_q, neg_main_n;
    logic              neg_rem_q, neg_rem_n;
    logic [XLEN-1:0]   m_q, m_n;
    logic [XLEN-1:0]   hi_q, hi_n;
    logic [XLEN-1:0]   lo_q, lo_n;
    logic              busy_n, done_n;
    logic [XLEN-1:0]   result_n;

    // Operand decode for acceptance in IDLE
    logic              a_sgn, b_sgn, a_neg, b_neg, is_div;
    logic [XLEN-1:0]   a_mag, b_mag;

    assign is_div = funct3[2];
    assign a_sgn  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_sgn  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg  = a_sgn & a[XLEN-1];
    assign b_neg  = b_sgn & b[XLEN-1];
    assign a_mag  = a_neg ? (~a + XLEN'(1)) : a;
    assign b_mag  = b_neg ? (~b + XLEN'(1)) : b;

    // One iteration: multiply shifts {hi,lo} right, divide shifts left and trial-subtracts
    logic [XLEN:0]     mul_sum, mul_tmp, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, m_q};
        mul_tmp   = lo_q[0] ? mul_sum : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift[XLEN] || (div_shift[XLEN-1:0] >= m_q);
        if (f3_q[2]) begin
            step_hi = div_ge ? (div_shift[XLEN-1:0] - m_q) : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_tmp[XLEN:1];
            step_lo = {mul_tmp[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection from the last iteration's outputs
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        prod   = {step_hi, step_lo};
        prod_s = neg_main_q ? (~prod + (2*XLEN)'(1)) : prod;
        quo_s  = neg_main_q ? (~step_lo + XLEN'(1)) : step_lo;
        rem_s  = neg_rem_q  ? (~step_hi + XLEN'(1)) : step_hi;
        case (f3_q)
            F3_MUL:                        final_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_res = quo_s;
            F3_REM, F3_REMU:               final_res = rem_s;
            default:                       final_res = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        f3_n       = f3_q;
        neg_main_n = neg_main_q;
        neg_rem_n  = neg_rem_q;
        m_n        = m_q;
        hi_n       = hi_q;
        lo_n       = lo_q;
        result_n   = result;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = CALC;
                    cnt_n      = '0;
                    f3_n       = funct3;
                    m_n        = is_div ? b_mag : a_mag;
                    hi_n       = '0;
                    lo_n       = is_div ? a_mag : b_mag;
                    // b=0 leaves the raw all-ones quotient unsigned
                    neg_main_n = is_div ? ((a_neg ^ b_neg) && (b != '0)) : (a_neg ^ b_neg);
                    neg_rem_n  = a_neg;
                end
            end
            CALC: begin
                hi_n  = step_hi;
                lo_n  = step_lo;
                cnt_n = cnt + CW'(1);
                if (cnt == LAST_CNT) begin
                    state_n  = DONE;
                    result_n = final_res;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            f3_q       <= f3_n;
            neg_main_q <= neg_main_n;
            neg_rem_q  <= neg_rem_n;
            m_q        <= m_n;
            hi_q       <= hi_n;
            lo_q       <= lo_n;
            busy       <= busy_n;
            done       <= done_n;
            result     <= result_n;
        end
    end

endmodule
